// File: rtl/ajc_arith_status_unit_v_if.sv
// Result/flag bus between the arithmetic unit (master) and the status unit (slave),
// plus the branch-controller condition request/response.
interface ajc_arith_status_unit_v_if;
  logic       Arith_Valid;
  logic [7:0] Arith_Result;
  logic [3:0] Arith_CNVZ;
  logic       Chain_En;
  logic       Flag_Wr;
  logic [3:0] Flag_Wr_Data;
  logic       Sticky_Clr;
  logic       Cond_Eval;
  logic [3:0] Cond_Sel;
  logic [7:0] Result_Reg;
  logic [3:0] Status_CNVZ;
  logic       Sticky_V;
  logic       Cond_True;
  logic       Cond_Valid;

  modport master (
    output Arith_Valid, Arith_Result, Arith_CNVZ, Chain_En, Flag_Wr, Flag_Wr_Data,
           Sticky_Clr, Cond_Eval, Cond_Sel,
    input  Result_Reg, Status_CNVZ, Sticky_V, Cond_True, Cond_Valid
  );

  modport slave (
    input  Arith_Valid, Arith_Result, Arith_CNVZ, Chain_En, Flag_Wr, Flag_Wr_Data,
           Sticky_Clr, Cond_Eval, Cond_Sel,
    output Result_Reg, Status_CNVZ, Sticky_V, Cond_True, Cond_Valid
  );
endinterface

// File: rtl/ajc_arith_status_unit_v.sv
// Architectural result/status registers with sticky overflow, multi-byte zero chaining and a
// registered one-cycle condition evaluator for the branch controller.
module ajc_arith_status_unit_v #(
  parameter bit         FORWARD    = 1'b0,
  parameter logic [3:0] RESET_CNVZ = 4'b0000
) (
  input logic                      Clock,
  input logic                      Reset,
  ajc_arith_status_unit_v_if.slave bus
);

  logic [7:0] result_q, result_d;
  logic [3:0] status_q, status_d;
  logic       sticky_q, sticky_d;
  logic       cond_true_q, cond_true_d;
  logic       cond_valid_q;
  logic [3:0] eval_flags;
  logic       fc, fn, fv, fz, lt;
  logic       cond_hit;

  // Flag_Wr beats an arithmetic capture; chaining ANDs the new Z into the old one.
  always_comb begin
    status_d = status_q;
    if (bus.Flag_Wr) begin
      status_d = bus.Flag_Wr_Data;
    end else if (bus.Arith_Valid) begin
      status_d[3:1] = bus.Arith_CNVZ[3:1];
      status_d[0]   = bus.Chain_En ? (bus.Arith_CNVZ[0] & status_q[0]) : bus.Arith_CNVZ[0];
    end
  end

  always_comb begin
    result_d = bus.Arith_Valid ? bus.Arith_Result : result_q;
    sticky_d = (bus.Arith_Valid & bus.Arith_CNVZ[1]) | (bus.Flag_Wr & bus.Flag_Wr_Data[1]) |
               (sticky_q & ~bus.Sticky_Clr);
  end

  assign eval_flags         = FORWARD ? status_d : status_q;
  assign {fc, fn, fv, fz}   = eval_flags;
  assign lt                 = fn ^ fv;

  always_comb begin
    cond_hit = 1'b0;
    unique case (bus.Cond_Sel)
      4'h0: cond_hit = fz;
      4'h1: cond_hit = ~fz;
      4'h2: cond_hit = fc;
      4'h3: cond_hit = ~fc;
      4'h4: cond_hit = fn;
      4'h5: cond_hit = ~fn;
      4'h6: cond_hit = fv;
      4'h7: cond_hit = ~fv;
      4'h8: cond_hit = lt;
      4'h9: cond_hit = ~lt;
      4'hA: cond_hit = fc & ~fz;
      4'hB: cond_hit = ~fc | fz;
      4'hC: cond_hit = ~fz & ~lt;
      4'hD: cond_hit = fz | lt;
      4'hE: cond_hit = 1'b1;
      4'hF: cond_hit = 1'b0;
      default: cond_hit = 1'b0;
    endcase
  end

  assign cond_true_d = bus.Cond_Eval ? cond_hit : cond_true_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      result_q     <= 8'h00;
      status_q     <= RESET_CNVZ;
      sticky_q     <= 1'b0;
      cond_true_q  <= 1'b0;
      cond_valid_q <= 1'b0;
    end else begin
      result_q     <= result_d;
      status_q     <= status_d;
      sticky_q     <= sticky_d;
      cond_true_q  <= cond_true_d;
      cond_valid_q <= bus.Cond_Eval;
    end
  end

  assign bus.Result_Reg  = result_q;
  assign bus.Status_CNVZ = status_q;
  assign bus.Sticky_V    = sticky_q;
  assign bus.Cond_True   = cond_true_q;
  assign bus.Cond_Valid  = cond_valid_q;

endmodule

// File: tb/tb_ajc_arith_status_unit_v.sv
// Drives a stored-flag and a forwarding instance with the same stimulus: directed vector table,
// a reset-during-evaluation sequence, then random traffic against a behavioural model.
module tb_ajc_arith_status_unit_v;

  typedef struct {
    logic       rst;
    logic       av;
    logic [7:0] res;
    logic [3:0] cnvz;
    logic       chain;
    logic       fw;
    logic [3:0] fwd;
    logic       sclr;
    logic       ce;
    logic [3:0] sel;
  } in_t;

  typedef struct {
    in_t        i;
    logic [7:0] e_res;
    logic [3:0] e_cnvz;
    logic       e_sticky;
    logic       e_ct0;
    logic       e_ct1;
    logic       e_cv;
  } vec_t;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  ajc_arith_status_unit_v_if bus0 ();
  ajc_arith_status_unit_v_if bus1 ();

  ajc_arith_status_unit_v #(.FORWARD(1'b0), .RESET_CNVZ(4'b0000)) u_dut0 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus0)
  );

  ajc_arith_status_unit_v #(.FORWARD(1'b1), .RESET_CNVZ(4'b0000)) u_dut1 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  vec_t tbl[$];

  // Behavioural model state: flags kept as named bits.
  logic [7:0] m_res;
  logic       m_c, m_n, m_v, m_z, m_sticky, m_ct0, m_ct1, m_cv;

  function automatic in_t vin(logic rst, logic av, logic [7:0] res, logic [3:0] cnvz,
                              logic chain, logic fw, logic [3:0] fwd, logic sclr,
                              logic ce, logic [3:0] sel);
    in_t x;
    x.rst = rst; x.av = av; x.res = res; x.cnvz = cnvz; x.chain = chain;
    x.fw = fw; x.fwd = fwd; x.sclr = sclr; x.ce = ce; x.sel = sel;
    return x;
  endfunction

  task automatic add(in_t x, logic [7:0] r, logic [3:0] f, logic s, logic t0, logic t1,
                     logic v);
    vec_t e;
    e.i = x; e.e_res = r; e.e_cnvz = f; e.e_sticky = s; e.e_ct0 = t0; e.e_ct1 = t1;
    e.e_cv = v;
    tbl.push_back(e);
  endtask

  // Condition meaning as a branch would read it: equality, carry, sign, overflow, ordering.
  function automatic logic cond_of(logic [3:0] sel, logic c, logic n, logic v, logic z);
    logic signed_less, unsigned_higher, result;
    signed_less     = (n != v);
    unsigned_higher = c && !z;
    case (sel)
      4'h0: result = z;
      4'h1: result = !z;
      4'h2: result = c;
      4'h3: result = !c;
      4'h4: result = n;
      4'h5: result = !n;
      4'h6: result = v;
      4'h7: result = !v;
      4'h8: result = signed_less;
      4'h9: result = !signed_less;
      4'hA: result = unsigned_higher;
      4'hB: result = !unsigned_higher;
      4'hC: result = !signed_less && !z;
      4'hD: result = signed_less || z;
      4'hE: result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  task automatic model_step(in_t x);
    logic nc, nn, nv, nz;
    if (x.rst) begin
      m_res = 8'h00; {m_c, m_n, m_v, m_z} = 4'b0000;
      m_sticky = 1'b0; m_ct0 = 1'b0; m_ct1 = 1'b0; m_cv = 1'b0;
      return;
    end
    {nc, nn, nv, nz} = {m_c, m_n, m_v, m_z};
    if (x.fw) begin
      {nc, nn, nv, nz} = x.fwd;
    end else if (x.av) begin
      nc = x.cnvz[3]; nn = x.cnvz[2]; nv = x.cnvz[1];
      nz = x.chain ? (x.cnvz[0] && m_z) : x.cnvz[0];
    end
    if (x.ce) begin
      m_ct0 = cond_of(x.sel, m_c, m_n, m_v, m_z);
      m_ct1 = cond_of(x.sel, nc, nn, nv, nz);
    end
    m_cv = x.ce;
    if (x.av) m_res = x.res;
    if ((x.av && x.cnvz[1]) || (x.fw && x.fwd[1])) m_sticky = 1'b1;
    else if (x.sclr) m_sticky = 1'b0;
    {m_c, m_n, m_v, m_z} = {nc, nn, nv, nz};
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(in_t x);
    Reset = x.rst;
    bus0.Arith_Valid = x.av;  bus1.Arith_Valid = x.av;
    bus0.Arith_Result = x.res; bus1.Arith_Result = x.res;
    bus0.Arith_CNVZ = x.cnvz; bus1.Arith_CNVZ = x.cnvz;
    bus0.Chain_En = x.chain;  bus1.Chain_En = x.chain;
    bus0.Flag_Wr = x.fw;      bus1.Flag_Wr = x.fw;
    bus0.Flag_Wr_Data = x.fwd; bus1.Flag_Wr_Data = x.fwd;
    bus0.Sticky_Clr = x.sclr; bus1.Sticky_Clr = x.sclr;
    bus0.Cond_Eval = x.ce;    bus1.Cond_Eval = x.ce;
    bus0.Cond_Sel = x.sel;    bus1.Cond_Sel = x.sel;
  endtask

  // Drive, clock once, update the model, then sample 1 time unit after the edge.
  task automatic apply(in_t x);
    drive(x);
    @(posedge Clock);
    model_step(x);
    #1;
    drive(vin(0, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0));
  endtask

  task automatic check_model(string tag);
    check({tag, " result0"}, bus0.Result_Reg, m_res);
    check({tag, " result1"}, bus1.Result_Reg, m_res);
    check({tag, " cnvz0"}, {4'h0, bus0.Status_CNVZ}, {4'h0, m_c, m_n, m_v, m_z});
    check({tag, " cnvz1"}, {4'h0, bus1.Status_CNVZ}, {4'h0, m_c, m_n, m_v, m_z});
    check({tag, " sticky0"}, {7'h0, bus0.Sticky_V}, {7'h0, m_sticky});
    check({tag, " sticky1"}, {7'h0, bus1.Sticky_V}, {7'h0, m_sticky});
    check({tag, " cond_true0"}, {7'h0, bus0.Cond_True}, {7'h0, m_ct0});
    check({tag, " cond_true1"}, {7'h0, bus1.Cond_True}, {7'h0, m_ct1});
    check({tag, " cond_valid0"}, {7'h0, bus0.Cond_Valid}, {7'h0, m_cv});
    check({tag, " cond_valid1"}, {7'h0, bus1.Cond_Valid}, {7'h0, m_cv});
  endtask

  initial begin
    in_t x;
    drive(vin(0, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0));

    //         rst av res    cnvz   ch fw fwd    sc ce sel       res    cnvz   st t0 t1 cv
    add(vin(1, 1, 8'h55, 4'b1111, 0, 1, 4'b1111, 0, 1, 4'hE), 8'h00, 4'b0000, 0, 0, 0, 0);
    add(vin(0, 1, 8'h00, 4'b1001, 0, 0, 4'h0,    0, 0, 4'h0), 8'h00, 4'b1001, 0, 0, 0, 0);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    0, 1, 4'h0), 8'h00, 4'b1001, 0, 1, 1, 1);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    0, 1, 4'hA), 8'h00, 4'b1001, 0, 0, 0, 1);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    0, 0, 4'h0), 8'h00, 4'b1001, 0, 0, 0, 0);
    add(vin(0, 1, 8'h11, 4'b1001, 0, 0, 4'h0,    0, 0, 4'h0), 8'h11, 4'b1001, 0, 0, 0, 0);
    add(vin(0, 1, 8'h22, 4'b1000, 1, 0, 4'h0,    0, 0, 4'h0), 8'h22, 4'b1000, 0, 0, 0, 0);
    add(vin(0, 1, 8'h33, 4'b1001, 1, 0, 4'h0,    0, 1, 4'h0), 8'h33, 4'b1000, 0, 0, 0, 1);
    add(vin(0, 1, 8'h44, 4'b0110, 0, 0, 4'h0,    0, 0, 4'h0), 8'h44, 4'b0110, 1, 0, 0, 0);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    0, 1, 4'h8), 8'h44, 4'b0110, 1, 0, 0, 1);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    0, 1, 4'h9), 8'h44, 4'b0110, 1, 1, 1, 1);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    0, 1, 4'hC), 8'h44, 4'b0110, 1, 1, 1, 1);
    add(vin(0, 0, 8'h00, 4'h0,    0, 1, 4'b0100, 0, 0, 4'h0), 8'h44, 4'b0100, 1, 1, 1, 0);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    0, 1, 4'h8), 8'h44, 4'b0100, 1, 1, 1, 1);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    0, 1, 4'hD), 8'h44, 4'b0100, 1, 1, 1, 1);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    1, 0, 4'h0), 8'h44, 4'b0100, 0, 1, 1, 0);
    add(vin(0, 1, 8'h55, 4'b0010, 0, 0, 4'h0,    0, 0, 4'h0), 8'h55, 4'b0010, 1, 1, 1, 0);
    add(vin(0, 1, 8'h66, 4'b0000, 0, 0, 4'h0,    0, 0, 4'h0), 8'h66, 4'b0000, 1, 1, 1, 0);
    add(vin(0, 1, 8'h77, 4'b0010, 0, 0, 4'h0,    1, 0, 4'h0), 8'h77, 4'b0010, 1, 1, 1, 0);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    1, 0, 4'h0), 8'h77, 4'b0010, 0, 1, 1, 0);
    add(vin(0, 1, 8'h88, 4'b0001, 0, 0, 4'h0,    0, 1, 4'h0), 8'h88, 4'b0001, 0, 0, 1, 1);
    add(vin(0, 1, 8'h99, 4'b0001, 0, 1, 4'b0000, 0, 1, 4'h0), 8'h99, 4'b0000, 0, 1, 0, 1);
    add(vin(0, 0, 8'h00, 4'h0,    0, 1, 4'b0010, 1, 1, 4'hF), 8'h99, 4'b0010, 1, 0, 0, 1);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    0, 1, 4'hB), 8'h99, 4'b0010, 1, 1, 1, 1);
    add(vin(0, 0, 8'h00, 4'h0,    0, 0, 4'h0,    0, 1, 4'h2), 8'h99, 4'b0010, 1, 0, 0, 1);

    @(negedge Clock);
    foreach (tbl[k]) begin
      apply(tbl[k].i);
      check($sformatf("vec%0d result", k), bus0.Result_Reg, tbl[k].e_res);
      check($sformatf("vec%0d cnvz", k), {4'h0, bus0.Status_CNVZ}, {4'h0, tbl[k].e_cnvz});
      check($sformatf("vec%0d sticky", k), {7'h0, bus0.Sticky_V}, {7'h0, tbl[k].e_sticky});
      check($sformatf("vec%0d cond_true_fwd0", k), {7'h0, bus0.Cond_True},
            {7'h0, tbl[k].e_ct0});
      check($sformatf("vec%0d cond_true_fwd1", k), {7'h0, bus1.Cond_True},
            {7'h0, tbl[k].e_ct1});
      check($sformatf("vec%0d cond_valid", k), {7'h0, bus0.Cond_Valid}, {7'h0, tbl[k].e_cv});
      check($sformatf("vec%0d cond_valid_fwd1", k), {7'h0, bus1.Cond_Valid},
            {7'h0, tbl[k].e_cv});
    end

    // Back-to-back requests each pulse Cond_Valid; reset on a request cycle suppresses it.
    for (int k = 0; k < 3; k++) begin
      apply(vin(0, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 1, 4'hE));
      check($sformatf("b2b%0d cond_valid", k), {7'h0, bus0.Cond_Valid}, 8'h01);
      check($sformatf("b2b%0d cond_true", k), {7'h0, bus0.Cond_True}, 8'h01);
    end
    apply(vin(1, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 1, 4'hE));
    check("rst_eval cond_valid", {7'h0, bus0.Cond_Valid}, 8'h00);
    check("rst_eval cond_true", {7'h0, bus1.Cond_True}, 8'h00);
    check("rst_eval cnvz", {4'h0, bus0.Status_CNVZ}, 8'h00);
    apply(vin(0, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0));
    check("post_rst cond_valid", {7'h0, bus1.Cond_Valid}, 8'h00);

    for (int k = 0; k < 400; k++) begin
      x.rst   = ($urandom_range(0, 39) == 0);
      x.av    = $urandom_range(0, 1) == 1;
      x.res   = 8'($urandom);
      x.cnvz  = 4'($urandom);
      x.chain = $urandom_range(0, 2) == 0;
      x.fw    = $urandom_range(0, 4) == 0;
      x.fwd   = 4'($urandom);
      x.sclr  = $urandom_range(0, 5) == 0;
      x.ce    = $urandom_range(0, 1) == 1;
      x.sel   = 4'($urandom);
      apply(x);
      check_model($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
